seq_detect_ctrl: RTL

Run controller for serial pattern detection. It arms an internal overlapping Mealy-style matcher with a programmable pattern, counts matches, and ends the run on a target match count, an idle timeout, or an abort. It sits between the register/config side and a serial bit stream, and hands a per-bit match strobe plus run status to downstream logic.

---
 rtl/seq_detect_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_ctrl
// Description : Run controller around an overlapping Mealy pattern matcher,
//               ending a run on target count, idle timeout or abort.
// Revision    : 1.0 - initial release
// ============================================================================

module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             timed_out
);

  localparam int                  c_FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2,
    ST_TOUT   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [PAT_W-1:0]    r_pattern;
  logic [CNT_W-1:0]    r_target;
  logic [TO_W-1:0]     r_timeout;
  logic [PAT_W-2:0]    r_history;
  logic [c_FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]    r_count;
  logic [TO_W-1:0]     r_timer;

  logic                w_accept;
  logic                w_active;
  logic                w_shift;
  logic [PAT_W-1:0]    w_cand;
  logic                w_match;
  logic [CNT_W:0]      w_count_inc;
  logic                w_target_hit;
  logic                w_expire;

  // abort masks every SEARCH event in its cycle, including the match strobe
  assign w_accept     = start & ~abort & (r_state != ST_SEARCH);
  assign w_active     = (r_state == ST_SEARCH) & ~abort;
  assign w_shift      = w_active & in_valid;
  assign w_cand       = {r_history, in_bit};
  assign w_match      = w_shift & (r_fill == c_FILL_MAX) & (w_cand == r_pattern);

  // one extra bit keeps a saturated counter from aliasing onto the target
  assign w_count_inc  = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
  assign w_target_hit = w_match & (r_target != '0) & (w_count_inc == {1'b0, r_target});
  assign w_expire     = w_active & ~w_match & (r_timeout != '0) &
                        (r_timer == (r_timeout - TO_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_TOUT: begin
        if (w_accept) begin
          w_next_state = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (w_target_hit) begin
          w_next_state = ST_DONE;
        end else if (w_expire) begin
          w_next_state = ST_TOUT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= '0;
      r_target  <= '0;
      r_timeout <= '0;
    end else if (w_accept) begin
      r_pattern <= cfg_pattern;
      r_target  <= cfg_target;
      r_timeout <= cfg_timeout;
    end
  end

  // History is kept across matches so overlapping occurrences are found
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (w_accept) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (w_shift) begin
      r_history <= w_cand[PAT_W-2:0];
      if (r_fill != c_FILL_MAX) begin
        r_fill <= r_fill + c_FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= '0;
    end else if (w_match && (r_count != '1)) begin
      r_count <= w_count_inc[CNT_W-1:0];
    end
  end

  // Timer runs on every SEARCH cycle, valid or not; a match restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_accept) begin
      r_timer <= '0;
    end else if (w_active) begin
      if (w_match) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TO_W'(1);
      end
    end
  end

  assign match       = w_match;
  assign match_count = r_count;
  assign busy        = (r_state == ST_SEARCH);
  assign done        = (r_state == ST_DONE);
  assign timed_out   = (r_state == ST_TOUT);

endmodule

`default_nettype wire
